// File: rtl/i2c_slave_pkg.sv
// rtl/i2c_slave_pkg.sv - shared state encoding and widths for the I2C slave byte engine
package i2c_slave_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

endpackage

// File: rtl/i2c_slave_bus_cond.sv
// rtl/i2c_slave_bus_cond.sv - START/STOP detector: SDA edge while SCL is high
module i2c_slave_bus_cond
  import i2c_slave_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda_ne,
  input  logic sda_pe,
  output logic start_c,
  output logic stop_c,
  output logic start_det,
  output logic stop_det
);

  logic start_q;
  logic stop_q;

  // Combinational strobes let the FSM act on the condition in the same cycle.
  assign start_c = scl & sda_ne;
  assign stop_c  = scl & sda_pe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= start_c;
      stop_q  <= stop_c;
    end
  end

  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_slave_byte_engine.sv
// rtl/i2c_slave_byte_engine.sv - I2C slave bit/byte engine: address match, write receive, read serialise, ACK drive
module i2c_slave_byte_engine
  import i2c_slave_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h27
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  input  logic                  scl_ne,
  input  logic                  scl_pe,
  input  logic                  sda,
  input  logic                  sda_ne,
  input  logic                  sda_pe,
  output logic                  sda_pull,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic                  tx_req,
  output logic                  start_det,
  output logic                  stop_det,
  output logic                  addressed,
  output logic                  rw,
  output logic                  nack_rx
);

  state_e                  state_q;
  logic [2:0]              bitcnt_q;
  logic                    done_q;
  logic [I2C_BYTE_W-1:0]   shift_q;
  logic [I2C_BYTE_W-1:0]   txsh_q;
  logic [I2C_BYTE_W-1:0]   rx_data_q;
  logic                    sda_pull_q;
  logic                    addressed_q;
  logic                    rw_q;
  logic                    rx_valid_q;
  logic                    tx_req_q;
  logic                    nack_rx_q;
  logic                    start_c;
  logic                    stop_c;

  i2c_slave_bus_cond u_bus_cond (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda_ne    (sda_ne),
    .sda_pe    (sda_pe),
    .start_c   (start_c),
    .stop_c    (stop_c),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd0;
      done_q      <= 1'b0;
      shift_q     <= '0;
      txsh_q      <= '0;
      rx_data_q   <= '0;
      sda_pull_q  <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      nack_rx_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      nack_rx_q  <= 1'b0;
      // tx_data is captured in the cycle the request pulse is visible upstream.
      if (tx_req_q) txsh_q <= tx_data;

      if (start_c) begin
        state_q     <= ST_ADDR;
        bitcnt_q    <= 3'd0;
        done_q      <= 1'b0;
        shift_q     <= '0;
        sda_pull_q  <= 1'b0;
        addressed_q <= 1'b0;
      end else if (stop_c) begin
        state_q     <= ST_IDLE;
        bitcnt_q    <= 3'd0;
        done_q      <= 1'b0;
        sda_pull_q  <= 1'b0;
        addressed_q <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR: begin
            if (scl_pe) begin
              shift_q  <= {shift_q[6:0], sda};
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) done_q <= 1'b1;
            end else if (scl_ne && done_q) begin
              done_q   <= 1'b0;
              bitcnt_q <= 3'd0;
              if (shift_q[7:1] == SLAVE_ADDR) begin
                state_q     <= ST_ADDR_ACK;
                sda_pull_q  <= 1'b1;
                addressed_q <= 1'b1;
                rw_q        <= shift_q[0];
                tx_req_q    <= shift_q[0];
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_ne) begin
              bitcnt_q   <= 3'd0;
              state_q    <= rw_q ? ST_RD_DATA : ST_WR_DATA;
              sda_pull_q <= rw_q ? ~txsh_q[7] : 1'b0;
            end
          end
          ST_WR_DATA: begin
            if (scl_pe) begin
              shift_q  <= {shift_q[6:0], sda};
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                done_q     <= 1'b1;
                rx_data_q  <= {shift_q[6:0], sda};
                rx_valid_q <= 1'b1;
              end
            end else if (scl_ne && done_q) begin
              done_q     <= 1'b0;
              state_q    <= ST_WR_ACK;
              sda_pull_q <= 1'b1;
            end
          end
          ST_WR_ACK: begin
            if (scl_ne) begin
              sda_pull_q <= 1'b0;
              bitcnt_q   <= 3'd0;
              state_q    <= ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            if (scl_ne) begin
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                sda_pull_q <= 1'b0;
                done_q     <= 1'b0;
                state_q    <= ST_RD_ACK;
              end else begin
                txsh_q     <= {txsh_q[6:0], 1'b0};
                sda_pull_q <= ~txsh_q[6];
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_pe) begin
              if (!sda) begin
                tx_req_q <= 1'b1;
                done_q   <= 1'b1;
              end else begin
                nack_rx_q <= 1'b1;
                state_q   <= ST_IGNORE;
              end
            end else if (scl_ne && done_q) begin
              done_q     <= 1'b0;
              bitcnt_q   <= 3'd0;
              state_q    <= ST_RD_DATA;
              sda_pull_q <= ~txsh_q[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_pull  = sda_pull_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign addressed = addressed_q;
  assign rw        = rw_q;
  assign nack_rx   = nack_rx_q;

endmodule
